r5p_htif_tohost: RTL and testbench

Synthesizable HTIF-style test-termination peripheral on the LSU-side TCB bus. It sits downstream of the core's load/store port, behind the address decoder. The test program writes a pass/fail code to TOHOST, or characters to CONSOLE, and the block reports termination status to the bench or board. It replaces the simulation-only tohost watcher so the same compliance binaries can also run on FPGA.

---
 rtl/r5p_htif_tohost.sv | 98 +++++++++
 tb/tb_r5p_htif_tohost.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_htif_tohost.sv
// rtl/r5p_htif_tohost.sv - HTIF-style test termination peripheral on the LSU TCB bus
// Latches the TOHOST exit code, echoes CONSOLE characters and forces a timeout if the test never ends.
module r5p_htif_tohost #(
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tcb_vld,
  output logic             tcb_rdy,
  input  logic             tcb_wen,
  input  logic [3:0]       tcb_adr,
  input  logic [1:0]       tcb_siz,
  input  logic [31:0]      tcb_wdt,
  output logic [31:0]      tcb_rdt,
  output logic             tcb_err,
  output logic             htif_done,
  output logic             htif_pass,
  output logic [30:0]      htif_code,
  output logic [CNT_W-1:0] htif_cyc,
  output logic             con_vld,
  output logic [7:0]       con_dat
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] tohost;
  logic [31:0] rd_dat;
  logic        acc_err;
  logic        wr_tohost;
  logic        wr_console;

  assign tcb_rdy   = 1'b1;
  assign htif_done = (state != ST_RUN);
  assign htif_pass = (state == ST_PASS);
  assign htif_code = tohost[31:1];

  always_comb begin
    acc_err    = (tcb_siz != 2'd2) || (tcb_adr[1:0] != 2'b00) || (tcb_wen && tcb_adr[3]);
    // TOHOST writes after termination are acknowledged but dropped
    wr_tohost  = tcb_vld && tcb_wen && !acc_err && (tcb_adr[3:2] == 2'd0) && (state == ST_RUN);
    wr_console = tcb_vld && tcb_wen && !acc_err && (tcb_adr[3:2] == 2'd1);
    rd_dat     = 32'd0;
    if (!tcb_wen && !acc_err) begin
      case (tcb_adr[3:2])
        2'd0:    rd_dat = tohost;
        2'd2:    rd_dat = 32'(htif_cyc);
        2'd3:    rd_dat = {30'd0, state};
        default: rd_dat = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      // a terminating write on the timeout edge takes priority
      if (wr_tohost && tcb_wdt[0])
        state_nxt = (tcb_wdt[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
      else if (htif_cyc == CYC_LAST)
        state_nxt = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      tohost   <= 32'd0;
      htif_cyc <= '0;
      tcb_rdt  <= 32'd0;
      tcb_err  <= 1'b0;
      con_vld  <= 1'b0;
      con_dat  <= 8'd0;
    end else begin
      state   <= state_nxt;
      con_vld <= wr_console;
      if (state == ST_RUN)
        htif_cyc <= htif_cyc + 1'b1;
      if (wr_tohost)
        tohost <= tcb_wdt;
      if (wr_console)
        con_dat <= tcb_wdt[7:0];
      if (tcb_vld) begin
        tcb_rdt <= rd_dat;
        tcb_err <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_r5p_htif_tohost.sv
// tb/tb_r5p_htif_tohost.sv - self-checking bench for r5p_htif_tohost
module tb_r5p_htif_tohost;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tcb_vld = 1'b0;
  logic        tcb_rdy;
  logic        tcb_wen = 1'b0;
  logic [3:0]  tcb_adr = 4'd0;
  logic [1:0]  tcb_siz = 2'd2;
  logic [31:0] tcb_wdt = 32'd0;
  logic [31:0] tcb_rdt;
  logic        tcb_err;
  logic        htif_done;
  logic        htif_pass;
  logic [30:0] htif_code;
  logic [31:0] htif_cyc;
  logic        con_vld;
  logic [7:0]  con_dat;

  int checks = 0;
  int errors = 0;
  int n_edges;

  r5p_htif_tohost #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_siz(tcb_siz), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
    .htif_done(htif_done), .htif_pass(htif_pass), .htif_code(htif_code), .htif_cyc(htif_cyc),
    .con_vld(con_vld), .con_dat(con_dat)
  );

  always #5 clk = ~clk;

  // clock edges seen since reset release: the reference for the RUN-state counter
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    tcb_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one transfer; returns #1 after the edge so the registered response is visible
  task automatic xfer(input logic w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    tcb_vld = 1'b1; tcb_wen = w; tcb_adr = a; tcb_siz = s; tcb_wdt = d;
    @(posedge clk);
    #1;
    tcb_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({tcb_rdt, tcb_err, htif_done, htif_pass, htif_code, htif_cyc, con_vld, con_dat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdt=%h err=%b done=%b pass=%b code=%h cyc=%0d con=%b/%h required all zero",
               tcb_rdt, tcb_err, htif_done, htif_pass, htif_code, htif_cyc, con_vld, con_dat);
    end
    checks++;
    if (tcb_rdy !== 1'b1) begin errors++; $display("FAIL rdy got %b required 1", tcb_rdy); end
  endtask

  task automatic test_timeout();
    int rise_at;
    do_reset();
    rise_at = -1;
    for (int i = 0; i < 4 * TMO && rise_at < 0; i++) begin
      @(posedge clk); #1;
      if (htif_done) rise_at = n_edges;
    end
    checks++;
    if (rise_at != TMO) begin errors++; $display("FAIL timeout_edge got %0d required %0d", rise_at, TMO); end
    checks++;
    if (htif_cyc !== 32'(TMO) || htif_pass !== 1'b0) begin
      errors++; $display("FAIL timeout_cyc cyc=%0d pass=%b required %0d/0", htif_cyc, htif_pass, TMO);
    end
    xfer(1'b0, 4'hC, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd3 || tcb_err !== 1'b0) begin
      errors++; $display("FAIL timeout_status got %h err=%b required 3", tcb_rdt, tcb_err);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (htif_cyc !== 32'(TMO) || htif_done !== 1'b1) begin
      errors++; $display("FAIL timeout_frozen cyc=%0d done=%b required %0d/1", htif_cyc, htif_done, TMO);
    end
    xfer(1'b0, 4'h8, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'(TMO)) begin errors++; $display("FAIL timeout_cycle_read got %0d required %0d", tcb_rdt, TMO); end
  endtask

  task automatic test_pass();
    do_reset();
    xfer(1'b1, 4'h0, 2'd2, 32'h1);
    checks++;
    if (tcb_err !== 1'b0 || htif_done !== 1'b1 || htif_pass !== 1'b1 || htif_code !== 31'd0) begin
      errors++; $display("FAIL pass_term err=%b done=%b pass=%b code=%h required 0/1/1/0", tcb_err, htif_done, htif_pass, htif_code);
    end
    xfer(1'b0, 4'hC, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd1) begin errors++; $display("FAIL pass_status got %h required 1", tcb_rdt); end
    xfer(1'b1, 4'h0, 2'd2, 32'h7);
    checks++;
    if (tcb_err !== 1'b0) begin errors++; $display("FAIL pass_late_write_err got %b required 0", tcb_err); end
    xfer(1'b0, 4'h0, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'h1 || htif_pass !== 1'b1 || htif_code !== 31'd0) begin
      errors++; $display("FAIL pass_sticky tohost=%h pass=%b code=%h required 1/1/0", tcb_rdt, htif_pass, htif_code);
    end
  endtask

  task automatic test_fail();
    logic [31:0] v, e;
    for (int k = 0; k < 3; k++) begin
      v = (k == 0) ? 32'h7 : ($urandom | 32'h1);
      if (v[31:1] == 31'd0) v = 32'h3;
      do_reset();
      xfer(1'b1, 4'h0, 2'd2, v);
      checks++;
      if (htif_done !== 1'b1 || htif_pass !== 1'b0 || htif_code !== 31'(v >> 1)) begin
        errors++; $display("FAIL fail_term v=%h done=%b pass=%b code=%h required 1/0/%h", v, htif_done, htif_pass, htif_code, v >> 1);
      end
      xfer(1'b0, 4'hC, 2'd2, 32'd0);
      checks++;
      if (tcb_rdt !== 32'd2) begin errors++; $display("FAIL fail_status got %h required 2", tcb_rdt); end
    end
    do_reset();
    e = (k_even());
    xfer(1'b1, 4'h0, 2'd2, e);
    xfer(1'b0, 4'h0, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== e || htif_done !== 1'b0) begin
      errors++; $display("FAIL even_write_store got %h done=%b required %h/0", tcb_rdt, htif_done, e);
    end
    xfer(1'b1, 4'h0, 2'd2, 32'h6);
    xfer(1'b0, 4'h0, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'h6 || htif_done !== 1'b0) begin
      errors++; $display("FAIL six_write_store got %h done=%b required 6/0", tcb_rdt, htif_done);
    end
  endtask

  function automatic logic [31:0] k_even();
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  task automatic test_back_to_back();
    logic [7:0] c [4];
    c[0] = 8'h41; c[1] = 8'h42; c[2] = 8'($urandom); c[3] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 4'h4, 2'd2, {24'($urandom), c[i]});
      checks++;
      if (con_vld !== 1'b1 || con_dat !== c[i] || tcb_err !== 1'b0) begin
        errors++; $display("FAIL console_%0d vld=%b dat=%h err=%b required 1/%h/0", i, con_vld, con_dat, tcb_err, c[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (con_vld !== 1'b0 || con_dat !== c[3]) begin
      errors++; $display("FAIL console_hold vld=%b dat=%h required 0/%h", con_vld, con_dat, c[3]);
    end
    xfer(1'b0, 4'h4, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd0 || tcb_err !== 1'b0 || con_vld !== 1'b0) begin
      errors++; $display("FAIL console_read rdt=%h err=%b vld=%b required 0/0/0", tcb_rdt, tcb_err, con_vld);
    end
  endtask

  task automatic test_errors();
    logic [3:0]  a [5];
    logic [1:0]  s [5];
    logic        w [5];
    a[0] = 4'h0; s[0] = 2'd0; w[0] = 1'b1;
    a[1] = 4'h2; s[1] = 2'd2; w[1] = 1'b1;
    a[2] = 4'h8; s[2] = 2'd2; w[2] = 1'b1;
    a[3] = 4'hC; s[3] = 2'd2; w[3] = 1'b1;
    a[4] = {2'($urandom), 2'd0}; s[4] = 2'd1 + 2'($urandom_range(0, 1)) * 2'd2; w[4] = 1'($urandom);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(w[i], a[i], s[i], 32'h1);
      checks++;
      if (tcb_err !== 1'b1 || tcb_rdt !== 32'd0 || htif_done !== 1'b0 || con_vld !== 1'b0) begin
        errors++; $display("FAIL err_case_%0d err=%b rdt=%h done=%b con=%b required 1/0/0/0", i, tcb_err, tcb_rdt, htif_done, con_vld);
      end
    end
    xfer(1'b0, 4'h0, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd0 || tcb_err !== 1'b0) begin errors++; $display("FAIL err_tohost_clean got %h err=%b required 0/0", tcb_rdt, tcb_err); end
    xfer(1'b0, 4'hC, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd0) begin errors++; $display("FAIL err_status got %h required 0", tcb_rdt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (TMO - 1) @(posedge clk);
    xfer(1'b1, 4'h0, 2'd2, 32'h1);
    checks++;
    if (htif_pass !== 1'b1 || htif_done !== 1'b1 || htif_cyc !== 32'(TMO) || n_edges != TMO) begin
      errors++; $display("FAIL simul_pass pass=%b done=%b cyc=%0d edge=%0d required 1/1/%0d/%0d", htif_pass, htif_done, htif_cyc, n_edges, TMO, TMO);
    end
    xfer(1'b0, 4'hC, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd1) begin errors++; $display("FAIL simul_status got %h required 1", tcb_rdt); end
    xfer(1'b1, 4'h4, 2'd2, 32'h5A);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({tcb_rdt, tcb_err, htif_done, htif_pass, htif_code, htif_cyc, con_vld, con_dat} !== '0) begin
      errors++; $display("FAIL async_reset rdt=%h done=%b pass=%b cyc=%0d con_dat=%h required all zero",
                         tcb_rdt, htif_done, htif_pass, htif_cyc, con_dat);
    end
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 4'hC, 2'd2, 32'd0);
    checks++;
    if (tcb_rdt !== 32'd0 || htif_done !== 1'b0) begin
      errors++; $display("FAIL after_reset_status got %h done=%b required 0/0", tcb_rdt, htif_done);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pass();
    test_fail();
    test_back_to_back();
    test_errors();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
